// File: rtl/module_rpeak_detector.sv
// R-peak detector: threshold-crossing peak tracker with over-width artifact rejection
// and a refractory mask. Reports peak amplitude and RR interval (in sample events) per beat.
module module_rpeak_detector #(
  parameter logic [15:0] REFRACT = 16'd50,
  parameter logic [15:0] MAXW    = 16'd40
) (
  input  logic        qzt_clk,
  input  logic        rst_n,
  input  logic        clk_in,
  input  logic [19:0] Vin,
  input  logic [19:0] threshold,
  output logic        beat,
  output logic        artifact,
  output logic [19:0] peak_amp,
  output logic [15:0] rr_interval,
  output logic        rr_valid
);

  typedef enum logic [1:0] {
    SEARCH     = 2'd0,
    PEAK       = 2'd1,
    REFRACTORY = 2'd2
  } state_t;

  state_t      state_r;
  logic        clk_in_old_r;
  logic        first_seen_r;
  logic [19:0] peak_reg_r;
  logic [15:0] w_r;
  logic [15:0] ref_cnt_r;
  logic [15:0] rr_cnt_r;
  logic        beat_r;
  logic        artifact_r;
  logic        rr_valid_r;
  logic [19:0] peak_amp_r;
  logic [15:0] rr_interval_r;

  logic        ev_s;
  logic        above_s;
  logic        vin_gt_pk_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Sample-event detection and signed comparisons against threshold and running peak
  always_comb begin
    ev_s        = clk_in & ~clk_in_old_r;
    above_s     = $signed(Vin) > $signed(threshold);
    vin_gt_pk_s = $signed(Vin) > $signed(peak_reg_r);
  end

  // Detector state machine; all outputs are registered and advance only on sample events
  always_ff @(posedge qzt_clk) begin
    if (!rst_n) begin
      state_r       <= SEARCH;
      clk_in_old_r  <= 1'b0;
      first_seen_r  <= 1'b0;
      peak_reg_r    <= 20'd0;
      w_r           <= 16'd0;
      ref_cnt_r     <= 16'd0;
      rr_cnt_r      <= 16'd0;
      beat_r        <= 1'b0;
      artifact_r    <= 1'b0;
      rr_valid_r    <= 1'b0;
      peak_amp_r    <= 20'd0;
      rr_interval_r <= 16'd0;
    end else begin
      clk_in_old_r <= clk_in;
      beat_r       <= 1'b0;
      artifact_r   <= 1'b0;
      rr_valid_r   <= 1'b0;
      if (ev_s) begin
        // Beat branch below overrides this with a clear
        rr_cnt_r <= sat_inc(rr_cnt_r);
        case (state_r)
          SEARCH: begin
            if (above_s) begin
              state_r    <= PEAK;
              peak_reg_r <= Vin;
              w_r        <= 16'd1;
            end
          end
          PEAK: begin
            if (above_s) begin
              if (vin_gt_pk_s) begin
                peak_reg_r <= Vin;
              end
              if (w_r == MAXW) begin
                artifact_r <= 1'b1;
                state_r    <= REFRACTORY;
                ref_cnt_r  <= REFRACT;
              end else begin
                w_r <= w_r + 16'd1;
              end
            end else begin
              beat_r     <= 1'b1;
              peak_amp_r <= peak_reg_r;
              if (first_seen_r) begin
                rr_interval_r <= sat_inc(rr_cnt_r);
                rr_valid_r    <= 1'b1;
              end
              first_seen_r <= 1'b1;
              rr_cnt_r     <= 16'd0;
              state_r      <= REFRACTORY;
              ref_cnt_r    <= REFRACT;
            end
          end
          REFRACTORY: begin
            // The event that sees ref_cnt==1 is consumed here; SEARCH looks at the next one
            if (ref_cnt_r == 16'd1) begin
              state_r <= SEARCH;
            end else begin
              ref_cnt_r <= ref_cnt_r - 16'd1;
            end
          end
          default: begin
            state_r <= SEARCH;
          end
        endcase
      end
    end
  end

  assign beat        = beat_r;
  assign artifact    = artifact_r;
  assign rr_valid    = rr_valid_r;
  assign peak_amp    = peak_amp_r;
  assign rr_interval = rr_interval_r;

endmodule

// File: tb/tb_module_rpeak_detector.sv
// Bench for module_rpeak_detector: event-index reference model compared every cycle,
// plus literal expectations at the points the directed vectors were designed around.
module tb_module_rpeak_detector;

  localparam int REF_N = 4;
  localparam int MAXW_N = 8;

  logic        qzt_clk;
  logic        rst_n;
  logic        clk_in;
  logic [19:0] Vin;
  logic [19:0] threshold;
  logic        beat;
  logic        artifact;
  logic [19:0] peak_amp;
  logic [15:0] rr_interval;
  logic        rr_valid;

  int checks = 0;
  int failures = 0;

  module_rpeak_detector #(.REFRACT(16'd4), .MAXW(16'd8)) dut (
    .qzt_clk    (qzt_clk),
    .rst_n      (rst_n),
    .clk_in     (clk_in),
    .Vin        (Vin),
    .threshold  (threshold),
    .beat       (beat),
    .artifact   (artifact),
    .peak_amp   (peak_amp),
    .rr_interval(rr_interval),
    .rr_valid   (rr_valid)
  );

  initial qzt_clk = 1'b0;
  always #5 qzt_clk = ~qzt_clk;

  // Reference model: events are numbered; the RR interval is the index difference
  bit                 started = 1'b0;
  bit                 m_prev;
  int                 ev_idx;
  int                 last_beat_idx;
  bit                 have_beat;
  bit                 in_exc;
  int                 width;
  int                 ignore_left;
  logic signed [19:0] pk;
  logic               exp_beat, exp_art, exp_rrv;
  logic [19:0]        exp_pk;
  logic [15:0]        exp_rr;

  always @(posedge qzt_clk) begin
    started = 1'b1;
    if (!rst_n) begin
      m_prev = 1'b0; ev_idx = 0; last_beat_idx = 0; have_beat = 1'b0;
      in_exc = 1'b0; width = 0; ignore_left = 0; pk = 20'sd0;
      exp_beat = 1'b0; exp_art = 1'b0; exp_rrv = 1'b0;
      exp_pk = 20'd0; exp_rr = 16'd0;
    end else begin
      exp_beat = 1'b0; exp_art = 1'b0; exp_rrv = 1'b0;
      if (clk_in && !m_prev) begin
        ev_idx++;
        if (ignore_left > 0) begin
          ignore_left--;
        end else if (!in_exc) begin
          if ($signed(Vin) > $signed(threshold)) begin
            in_exc = 1'b1; pk = $signed(Vin); width = 1;
          end
        end else if ($signed(Vin) > $signed(threshold)) begin
          if ($signed(Vin) > pk) pk = $signed(Vin);
          if (width == MAXW_N) begin
            exp_art = 1'b1; in_exc = 1'b0; ignore_left = REF_N;
          end else begin
            width++;
          end
        end else begin
          exp_beat = 1'b1;
          exp_pk = pk;
          if (have_beat) begin
            exp_rrv = 1'b1;
            exp_rr = (ev_idx - last_beat_idx > 65535) ? 16'hFFFF : 16'(ev_idx - last_beat_idx);
          end
          have_beat = 1'b1; last_beat_idx = ev_idx;
          in_exc = 1'b0; ignore_left = REF_N;
        end
      end
      m_prev = clk_in;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model
  always @(negedge qzt_clk) begin
    if (started) begin
      checks++;
      if ({beat, artifact, rr_valid, peak_amp, rr_interval} !==
          {exp_beat, exp_art, exp_rrv, exp_pk, exp_rr}) begin
        failures++;
        $display("FAIL model_cmp t=%0t beat/art/rrv/pk/rr act=%b/%b/%b/%h/%h exp=%b/%b/%b/%h/%h",
                 $time, beat, artifact, rr_valid, peak_amp, rr_interval,
                 exp_beat, exp_art, exp_rrv, exp_pk, exp_rr);
      end
    end
  end

  logic cap_beat, cap_art, cap_rrv;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // One sample event; called at a negedge, returns at a negedge two cycles later
  task automatic send(input logic [19:0] v);
    Vin = v;
    clk_in = 1'b1;
    @(negedge qzt_clk);
    cap_beat = beat; cap_art = artifact; cap_rrv = rr_valid;
    clk_in = 1'b0;
    @(negedge qzt_clk);
  endtask

  task automatic send_n(input logic [19:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  initial begin
    rst_n = 1'b0; clk_in = 1'b0; Vin = 20'd0; threshold = 20'd1000;
    repeat (3) @(negedge qzt_clk);
    chk("reset_beat", {19'd0, beat}, 20'd0);
    chk("reset_peak_amp", peak_amp, 20'd0);
    chk("reset_rr_interval", {4'd0, rr_interval}, 20'd0);
    rst_n = 1'b1;
    @(negedge qzt_clk);

    // First beat: events 1..5
    send(20'd0); send(20'd1200); send(20'd1500); send(20'd1300);
    chk("first_no_early_beat", {19'd0, cap_beat}, 20'd0);
    send(20'd900);
    chk("first_beat", {19'd0, cap_beat}, 20'd1);
    chk("first_rr_valid", {19'd0, cap_rrv}, 20'd0);
    chk("first_peak_amp", peak_amp, 20'd1500);

    // Second beat falling on event 105
    send_n(20'd0, 95);
    send(20'd0); send(20'd1200); send(20'd1500); send(20'd1300); send(20'd900);
    chk("second_beat", {19'd0, cap_beat}, 20'd1);
    chk("second_rr_valid", {19'd0, cap_rrv}, 20'd1);
    chk("second_rr_interval", {4'd0, rr_interval}, 20'd100);

    // Events 106..109 ignored; 110 crosses; artifact on 118
    send_n(20'd2000, 4);
    send_n(20'd2000, 8);
    chk("artifact_not_early", {19'd0, cap_art}, 20'd0);
    send(20'd2000);
    chk("artifact_pulse", {19'd0, cap_art}, 20'd1);
    chk("artifact_no_beat", {19'd0, cap_beat}, 20'd0);
    chk("artifact_peak_kept", peak_amp, 20'd1500);

    // Refractory 119..122, then beat on 126 measured from beat 105
    send_n(20'd0, 4);
    send(20'd0); send(20'd1100); send(20'd1700); send(20'd900);
    chk("post_art_beat", {19'd0, cap_beat}, 20'd1);
    chk("post_art_rr", {4'd0, rr_interval}, 20'd21);
    chk("post_art_peak", peak_amp, 20'd1700);
    send_n(20'd0, 4);

    // Signed detection, beat on event 134
    threshold = 20'hFFE0C;
    send(20'hFFDA8); send(20'hFFE70); send(20'hFFE3E); send(20'hFFD44);
    chk("signed_beat", {19'd0, cap_beat}, 20'd1);
    chk("signed_peak", peak_amp, 20'hFFE70);
    chk("signed_rr", {4'd0, rr_interval}, 20'd8);

    // clk_in held high for 20 cycles counts as a single (ignored) event 135
    Vin = 20'hFFE70; clk_in = 1'b1;
    repeat (20) @(negedge qzt_clk);
    clk_in = 1'b0;
    @(negedge qzt_clk);
    send_n(20'hFFE70, 3);
    send(20'hFFE70);
    chk("hold_no_beat", {19'd0, cap_beat | cap_art}, 20'd0);
    send(20'hFFD44);
    chk("hold_single_event_beat", {19'd0, cap_beat}, 20'd1);
    chk("hold_rr", {4'd0, rr_interval}, 20'd6);

    // Reset in the middle of an excursion
    threshold = 20'd1000;
    send_n(20'd0, 4);
    send(20'd1500); send(20'd1600);
    rst_n = 1'b0;
    @(negedge qzt_clk);
    chk("midpeak_reset_peak", peak_amp, 20'd0);
    chk("midpeak_reset_rr", {4'd0, rr_interval}, 20'd0);
    chk("midpeak_reset_pulses", {17'd0, beat, artifact, rr_valid}, 20'd0);
    rst_n = 1'b1;
    @(negedge qzt_clk);
    send(20'd0); send(20'd1200); send(20'd800);
    chk("after_reset_beat", {19'd0, cap_beat}, 20'd1);
    chk("after_reset_no_rrv", {19'd0, cap_rrv}, 20'd0);
    chk("after_reset_peak", peak_amp, 20'd1200);

    // Long gap: interval saturates and rr_valid still pulses
    send_n(20'd0, 65540);
    send(20'd1200); send(20'd800);
    chk("sat_beat", {19'd0, cap_beat}, 20'd1);
    chk("sat_rr_valid", {19'd0, cap_rrv}, 20'd1);
    chk("sat_rr_interval", {4'd0, rr_interval}, 20'h0FFFF);

    repeat (2) @(negedge qzt_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/module_rpeak_detector.md
# module_rpeak_detector

R-peak detector for the ECG chain, fed directly by the low-pass filter output. Vin is the filtered 20-bit signed sample. Updates are qualified by the same slow sample strobe (clk_in) that clocks the filter, sampled on the quartz clock. The block finds R peaks by threshold crossing and peak tracking, then masks them with a refractory window. Per beat it reports peak amplitude and RR interval in samples, for the heart-rate and display stages downstream.

## Interface
- REFRACT, 16'd50: sample events ignored after each beat or artifact; legal range 1..65535
- MAXW, 16'd40: maximum above-threshold width in samples before the excursion is rejected as an artifact; legal range 1..65535
- qzt_clk  input  1  system (quartz) clock; all logic on posedge
- rst_n  input  1  synchronous, active-low reset
- clk_in  input  1  sample strobe; a 0→1 transition seen on qzt_clk is one sample event
- Vin  input  20  filtered sample, two's complement
- threshold  input  20  detection level, two's complement, sampled on each event
- beat  output  1  one-qzt_clk pulse per accepted R peak
- artifact  output  1  one-qzt_clk pulse per rejected over-wide excursion
- peak_amp  output  20  max Vin of last accepted beat, held
- rr_interval  output  16  samples between last two accepted beats, held
- rr_valid  output  1  one-cycle pulse with beat when rr_interval was updated

## Operation
- Edge detect: clk_in_old register; event = clk_in & ~clk_in_old. State advances only on event cycles.
- All compares are signed 20-bit. "Above" means Vin > threshold, strictly.
- rr_cnt (16 bit) increments on every event, saturating at 16'hFFFF, in all states. It is cleared on a beat event.
- SEARCH: if above, go to PEAK with peak_reg=Vin and w=1. Otherwise stay.
- PEAK, still above:
  - if Vin > peak_reg, set peak_reg=Vin;
  - if w==MAXW, pulse artifact, go to REFRACTORY, leave peak_amp unchanged, keep rr_cnt counting;
  - else w=w+1.
- PEAK, not above: this is a beat event.
  - pulse beat; peak_amp <= peak_reg.
  - if first_seen, rr_interval <= sat(rr_cnt+1) and pulse rr_valid.
  - set first_seen; clear rr_cnt; go to REFRACTORY.
- REFRACTORY: load ref_cnt=REFRACT on entry. Decrement on each following event. Go to SEARCH on the event where ref_cnt==1; Vin on that event is ignored. The first SEARCH evaluation is therefore the (REFRACT+1)th event after entry.
- Non-event cycles: no state change; beat, artifact and rr_valid are 0.
- Interval definition: rr_interval is the event-index difference between consecutive beat events. Saturation gives 16'hFFFF, with rr_valid still pulsed.

## Timing
- Reset (rst_n=0 at a posedge), all of these take effect at that edge:
  - state=SEARCH;
  - beat, artifact, rr_valid, peak_amp, rr_interval, rr_cnt, w, ref_cnt, peak_reg = 0;
  - first_seen=0, clk_in_old=0.
- Reset mid-PEAK or mid-REFRACTORY discards the excursion with no pulse. The next beat after reset gives no rr_valid.
- If clk_in is high when reset releases, that produces an event on the first cycle after release, because clk_in_old=0.
- Outputs are registered. beat, artifact, rr_valid and updated peak_amp/rr_interval are visible in the qzt_clk cycle following the event cycle. Pulses are exactly 1 qzt_clk wide.
- At most one of beat or artifact per event.
- threshold changes take effect at the next event. No handshake: downstream must sample beat/rr_valid each qzt_clk.
- clk_in held high produces one event only. Back-to-back events on consecutive qzt_clk cycles require clk_in to toggle and must be processed correctly.

## Test plan
- Reset, bench REFRACT=4, MAXW=8, threshold=1000:
  - Vin sequence 0,1200,1500,1300,900 (one per event) → beat 1 cycle after 5th event; peak_amp=1500; rr_valid=0.
- Second pulse of the same shape, whose falling event is 100 events after the first beat event → beat, rr_valid, rr_interval=100.
- Vin=2000 for 8 events after crossing → artifact pulse after the 8th event, no beat, peak_amp unchanged. Next beat's rr_interval counts from the previous beat.
- Above-threshold samples on events 1–4 after a beat are ignored. Event 5 above starts PEAK.
- Signed case: threshold=-500, Vin -600,-400,-450,-700 → beat with peak_amp=-400. Also hold clk_in high 20 qzt_clk → single event.
- Assert rst_n=0 mid-PEAK → outputs zero. The next accepted beat has rr_valid=0. Also check no beat for 70000 events then a beat pair → rr_interval=16'hFFFF.
